bsg_mla_wb_sequencer: RTL and testbench



---
 rtl/bsg_mla_wb_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_bsg_mla_wb_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mla_wb_sequencer.sv
// bsg_mla_wb_sequencer
// Writeback sequencer between the accelerator DPU beat output and the bedrock
// stream pump-out. Groups fill-width beats into block-sized bursts, addresses
// each burst from one of two auto-advancing destination cursors, and presents
// one registered beat per cycle with first/last markers.
//
// Optional feature macro: BSG_MLA_WB_BUF_CHECK_EN
//   When defined, a beat in the middle of a burst whose buffer tag differs
//   from the burst's tag sets the sticky error_o. When undefined, error_o is 0.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   base_data_i/sel_i/v_i   cursor load (sel 0 = dest0, 1 = dest1)
//   data_i, buf_i, v_i      input beat, destination buffer tag, valid
//   ready_and_o             input beat accepted when v_i & ready_and_o
//   data_o, addr_o          registered beat and its burst base address
//   first_o, last_o         burst markers for the registered beat
//   v_o, ready_and_i        output handshake toward the pump
//   cursor0_o, cursor1_o    current destination cursors
//   bursts_o                completed bursts (last beat accepted downstream)
//   busy_o                  burst in progress or output valid
//   error_o                 sticky buffer-tag mismatch error

module bsg_mla_wb_sequencer #(
  parameter int unsigned fill_width_p  = 64,
  parameter int unsigned block_width_p = 512,
  parameter int unsigned addr_width_p  = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [addr_width_p-1:0] base_data_i,
  input  logic                    base_sel_i,
  input  logic                    base_v_i,
  input  logic [fill_width_p-1:0] data_i,
  input  logic                    buf_i,
  input  logic                    v_i,
  output logic                    ready_and_o,
  output logic [fill_width_p-1:0] data_o,
  output logic [addr_width_p-1:0] addr_o,
  output logic                    first_o,
  output logic                    last_o,
  output logic                    v_o,
  input  logic                    ready_and_i,
  output logic [addr_width_p-1:0] cursor0_o,
  output logic [addr_width_p-1:0] cursor1_o,
  output logic [31:0]             bursts_o,
  output logic                    busy_o,
  output logic                    error_o
);

  localparam int unsigned beats_lp       = block_width_p / fill_width_p;
  localparam int unsigned block_bytes_lp = block_width_p / 8;
  localparam int unsigned cnt_width_lp   = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  typedef enum logic {eIDLE, eSTREAM} state_e;

  state_e                  state_q;
  logic [cnt_width_lp-1:0] cnt_q;
  logic                    buf_r_q;
  logic [addr_width_p-1:0] addr_r_q;
  logic [addr_width_p-1:0] cursor_q [2];
  logic [addr_width_p-1:0] cursor_d [2];

  logic [fill_width_p-1:0] data_o_q;
  logic [addr_width_p-1:0] addr_o_q;
  logic                    first_o_q;
  logic                    last_o_q;
  logic                    v_o_q;
  logic [31:0]             bursts_q;

  logic                    accept_c;
  logic                    is_last_c;
  logic                    adv_buf_c;
  logic [addr_width_p-1:0] beat_addr_c;

  // Single output register: refill whenever it is empty or draining this cycle.
  assign ready_and_o = ~v_o_q | ready_and_i;

  // Per-beat decode: burst start takes address/tag from the live cursor.
  always_comb begin
    accept_c    = v_i & ready_and_o;
    is_last_c   = (state_q == eIDLE) ? (beats_lp == 1)
                                     : (cnt_q == cnt_width_lp'(beats_lp - 1));
    adv_buf_c   = (state_q == eIDLE) ? buf_i : buf_r_q;
    beat_addr_c = (state_q == eIDLE) ? cursor_q[buf_i] : addr_r_q;
  end

  // Cursor next-state: a load beats a same-cycle advance of the same cursor.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      cursor_d[i] = cursor_q[i];
      if (base_v_i && (base_sel_i == 1'(i))) begin
        cursor_d[i] = base_data_i;
      end else if (accept_c && is_last_c && (adv_buf_c == 1'(i))) begin
        cursor_d[i] = cursor_q[i] + addr_width_p'(block_bytes_lp);
      end
    end
  end

  // Burst FSM, output register, cursors and burst counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= eIDLE;
      cnt_q       <= '0;
      buf_r_q     <= 1'b0;
      addr_r_q    <= '0;
      cursor_q[0] <= '0;
      cursor_q[1] <= '0;
      data_o_q    <= '0;
      addr_o_q    <= '0;
      first_o_q   <= 1'b0;
      last_o_q    <= 1'b0;
      v_o_q       <= 1'b0;
      bursts_q    <= '0;
    end else begin
      cursor_q[0] <= cursor_d[0];
      cursor_q[1] <= cursor_d[1];

      if (v_o_q && ready_and_i && last_o_q) begin
        bursts_q <= bursts_q + 32'd1;
      end

      if (accept_c) begin
        v_o_q     <= 1'b1;
        data_o_q  <= data_i;
        addr_o_q  <= beat_addr_c;
        first_o_q <= (state_q == eIDLE);
        last_o_q  <= is_last_c;
      end else if (ready_and_i) begin
        v_o_q <= 1'b0;
      end

      if (accept_c) begin
        case (state_q)
          eIDLE: begin
            buf_r_q  <= buf_i;
            addr_r_q <= cursor_q[buf_i];
            if (is_last_c) begin
              cnt_q   <= '0;
              state_q <= eIDLE;
            end else begin
              cnt_q   <= cnt_width_lp'(1);
              state_q <= eSTREAM;
            end
          end
          eSTREAM: begin
            if (is_last_c) begin
              cnt_q   <= '0;
              state_q <= eIDLE;
            end else begin
              cnt_q   <= cnt_q + cnt_width_lp'(1);
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= eIDLE;
          end
        endcase
      end
    end
  end

`ifdef BSG_MLA_WB_BUF_CHECK_EN
  logic error_q;

  // Sticky flag for a mid-burst beat whose tag disagrees with the burst's tag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      error_q <= 1'b0;
    end else if (accept_c && (state_q == eSTREAM) && (buf_i != buf_r_q)) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  assign data_o    = data_o_q;
  assign addr_o    = addr_o_q;
  assign first_o   = first_o_q;
  assign last_o    = last_o_q;
  assign v_o       = v_o_q;
  assign cursor0_o = cursor_q[0];
  assign cursor1_o = cursor_q[1];
  assign bursts_o  = bursts_q;
  assign busy_o    = (state_q == eSTREAM) | v_o_q;

endmodule

// File: tb/tb_bsg_mla_wb_sequencer.sv
// Directed self-checking bench for bsg_mla_wb_sequencer (default 64/512/64).
module tb_bsg_mla_wb_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [63:0] base_data_i = '0;
  logic        base_sel_i = 1'b0;
  logic        base_v_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        buf_i = 1'b0;
  logic        v_i = 1'b0;
  logic        ready_and_o;
  logic [63:0] data_o;
  logic [63:0] addr_o;
  logic        first_o;
  logic        last_o;
  logic        v_o;
  logic        ready_and_i = 1'b1;
  logic [63:0] cursor0_o;
  logic [63:0] cursor1_o;
  logic [31:0] bursts_o;
  logic        busy_o;
  logic        error_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_bursts = 0;

`ifdef BSG_MLA_WB_BUF_CHECK_EN
  localparam bit exp_err_en = 1'b1;
`else
  localparam bit exp_err_en = 1'b0;
`endif

  bsg_mla_wb_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .base_data_i(base_data_i), .base_sel_i(base_sel_i), .base_v_i(base_v_i),
    .data_i(data_i), .buf_i(buf_i), .v_i(v_i), .ready_and_o(ready_and_o),
    .data_o(data_o), .addr_o(addr_o), .first_o(first_o), .last_o(last_o),
    .v_o(v_o), .ready_and_i(ready_and_i),
    .cursor0_o(cursor0_o), .cursor1_o(cursor1_o), .bursts_o(bursts_o),
    .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_base(input logic sel, input logic [63:0] val);
    base_v_i = 1'b1; base_sel_i = sel; base_data_i = val;
    tick();
    base_v_i = 1'b0;
    checks++;
    if ((sel ? cursor1_o : cursor0_o) !== val) begin
      failures++;
      $display("FAIL load_base sel=%0d got=%h exp=%h", sel, sel ? cursor1_o : cursor0_o, val);
    end
  endtask

  // Full burst at ready_and_i=1; optional base load of dest0 on the last beat,
  // optional buffer-tag flip from beat flip_idx onward.
  task automatic run_burst(input logic b, input logic [63:0] exp_addr,
                           input logic [15:0] tag, input bit ld_en,
                           input logic [63:0] ld_val, input int flip_idx);
    logic [63:0] exp_data;
    ready_and_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v_i = 1'b1;
      exp_data = {tag, 48'(i)};
      data_i = exp_data;
      buf_i = (flip_idx >= 0 && i >= flip_idx) ? ~b : b;
      base_v_i = ld_en && (i == 7);
      base_sel_i = 1'b0;
      base_data_i = ld_val;
      tick();
      checks++;
      if (v_o !== 1'b1 || data_o !== exp_data || addr_o !== exp_addr) begin
        failures++;
        $display("FAIL burst_beat%0d v=%b data=%h addr=%h exp_data=%h exp_addr=%h",
                 i, v_o, data_o, addr_o, exp_data, exp_addr);
      end
      checks++;
      if (first_o !== (i == 0) || last_o !== (i == 7)) begin
        failures++;
        $display("FAIL burst_marks%0d first=%b last=%b", i, first_o, last_o);
      end
    end
    v_i = 1'b0; base_v_i = 1'b0; buf_i = 1'b0;
    tick();
    exp_bursts++;
    checks++;
    if (v_o !== 1'b0 || bursts_o !== exp_bursts || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL burst_end v=%b bursts=%0d exp=%0d busy=%b", v_o, bursts_o, exp_bursts, busy_o);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    checks++;
    if (v_o !== 0 || first_o !== 0 || last_o !== 0 || data_o !== 0 || addr_o !== 0 ||
        cursor0_o !== 0 || cursor1_o !== 0 || bursts_o !== 0 || busy_o !== 0 ||
        error_o !== 0 || ready_and_o !== 1) begin
      failures++;
      $display("FAIL reset_state v=%b f=%b l=%b d=%h a=%h c0=%h c1=%h b=%0d busy=%b err=%b rdy=%b",
               v_o, first_o, last_o, data_o, addr_o, cursor0_o, cursor1_o, bursts_o,
               busy_o, error_o, ready_and_o);
    end
    exp_bursts = 0;
  endtask

  task automatic test_basic();
    load_base(1'b0, 64'h8000_0000);
    run_burst(1'b0, 64'h8000_0000, 16'h0001, 1'b0, '0, -1);
    checks++;
    if (cursor0_o !== 64'h8000_0040) begin
      failures++;
      $display("FAIL basic_cursor0 got=%h exp=%h", cursor0_o, 64'h8000_0040);
    end
  endtask

  task automatic test_interleave();
    load_base(1'b0, 64'h1000);
    load_base(1'b1, 64'h2000);
    run_burst(1'b0, 64'h1000, 16'h0010, 1'b0, '0, -1);
    run_burst(1'b1, 64'h2000, 16'h0011, 1'b0, '0, -1);
    run_burst(1'b0, 64'h1040, 16'h0012, 1'b0, '0, -1);
    checks++;
    if (cursor0_o !== 64'h1080 || cursor1_o !== 64'h2040) begin
      failures++;
      $display("FAIL interleave_cursors c0=%h c1=%h exp=1080/2040", cursor0_o, cursor1_o);
    end
  endtask

  // Downstream stall of 5 cycles mid-burst with v_i held high.
  task automatic test_stall();
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    bit exp_rdy;
    bit prev_stall = 0;
    logic [63:0] hold_d = '0;
    logic [63:0] hold_a = '0;
    buf_i = 1'b0;
    while (out_idx < 8 && cyc < 100) begin
      ready_and_i = !(cyc >= 3 && cyc < 8);
      v_i = (in_idx < 8);
      data_i = 64'hA000 + 64'(in_idx);
      #1;
      if (prev_stall) begin
        checks++;
        if (data_o !== hold_d || addr_o !== hold_a || v_o !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold data=%h addr=%h v=%b exp_data=%h exp_addr=%h",
                   data_o, addr_o, v_o, hold_d, hold_a);
        end
      end
      exp_rdy = !v_o || ready_and_i;
      checks++;
      if (ready_and_o !== exp_rdy) begin
        failures++;
        $display("FAIL stall_ready cyc=%0d got=%b exp=%b", cyc, ready_and_o, exp_rdy);
      end
      if (v_o && ready_and_i) begin
        checks++;
        if (data_o !== 64'hA000 + 64'(out_idx) || addr_o !== 64'h1080 ||
            first_o !== (out_idx == 0) || last_o !== (out_idx == 7)) begin
          failures++;
          $display("FAIL stall_out%0d data=%h addr=%h first=%b last=%b",
                   out_idx, data_o, addr_o, first_o, last_o);
        end
        out_idx++;
      end
      prev_stall = v_o && !ready_and_i;
      hold_d = data_o;
      hold_a = addr_o;
      if (v_i && exp_rdy) in_idx++;
      @(posedge clk_i);
      #1;
      cyc++;
    end
    v_i = 1'b0;
    ready_and_i = 1'b1;
    exp_bursts++;
    checks++;
    if (out_idx != 8 || in_idx != 8 || bursts_o !== exp_bursts || v_o !== 1'b0 ||
        cursor0_o !== 64'h10C0) begin
      failures++;
      $display("FAIL stall_end outs=%0d ins=%0d bursts=%0d exp=%0d v=%b c0=%h",
               out_idx, in_idx, bursts_o, exp_bursts, v_o, cursor0_o);
    end
    tick();
  endtask

  task automatic test_load_collision();
    load_base(1'b0, 64'h1000);
    run_burst(1'b0, 64'h1000, 16'h0040, 1'b1, 64'h5000, -1);
    checks++;
    if (cursor0_o !== 64'h5000) begin
      failures++;
      $display("FAIL collision_cursor0 got=%h exp=%h", cursor0_o, 64'h5000);
    end
    run_burst(1'b0, 64'h5000, 16'h0041, 1'b0, '0, -1);
    checks++;
    if (cursor0_o !== 64'h5040) begin
      failures++;
      $display("FAIL collision_after got=%h exp=%h", cursor0_o, 64'h5040);
    end
  endtask

  task automatic test_wrap();
    load_base(1'b1, 64'hFFFF_FFFF_FFFF_FFC0);
    run_burst(1'b1, 64'hFFFF_FFFF_FFFF_FFC0, 16'h0050, 1'b0, '0, -1);
    checks++;
    if (cursor1_o !== 64'h0 || cursor0_o !== 64'h5040) begin
      failures++;
      $display("FAIL wrap_cursor c1=%h c0=%h exp=0/5040", cursor1_o, cursor0_o);
    end
  endtask

  task automatic test_buf_check();
    run_burst(1'b0, 64'h5040, 16'h0060, 1'b0, '0, 4);
    checks++;
    if (error_o !== exp_err_en || cursor0_o !== 64'h5080 || cursor1_o !== 64'h0) begin
      failures++;
      $display("FAIL buf_check err=%b exp=%b c0=%h c1=%h", error_o, exp_err_en, cursor0_o, cursor1_o);
    end
    tick(); tick();
    checks++;
    if (error_o !== exp_err_en) begin
      failures++;
      $display("FAIL buf_check_sticky err=%b exp=%b", error_o, exp_err_en);
    end
  endtask

  task automatic test_reset_mid_burst();
    ready_and_i = 1'b1;
    buf_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v_i = 1'b1;
      data_i = 64'hC000 + 64'(i);
      tick();
    end
    v_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || v_o !== 1'b1 || addr_o !== 64'h5080) begin
      failures++;
      $display("FAIL midburst_busy busy=%b v=%b addr=%h", busy_o, v_o, addr_o);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checks++;
    if (v_o !== 0 || busy_o !== 0 || cursor0_o !== 0 || cursor1_o !== 0 ||
        bursts_o !== 0 || error_o !== 0) begin
      failures++;
      $display("FAIL midburst_reset v=%b busy=%b c0=%h c1=%h bursts=%0d err=%b",
               v_o, busy_o, cursor0_o, cursor1_o, bursts_o, error_o);
    end
    exp_bursts = 0;
    // A fresh burst must start cleanly (first_o on beat 0) after the reset.
    run_burst(1'b1, 64'h0, 16'h0070, 1'b0, '0, -1);
    checks++;
    if (cursor1_o !== 64'h40 || cursor0_o !== 64'h0) begin
      failures++;
      $display("FAIL post_reset_cursor c1=%h c0=%h", cursor1_o, cursor0_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_stall();
    test_load_collision();
    test_wrap();
    test_buf_check();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
